// File: rtl/ssd_display_scheduler.sv
// ssd_display_scheduler: shares the two-digit display between three sources, with timed hold/gap and source-0 preemption.
module ssd_display_scheduler #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GAP_CYCLES = 10_000_000,
  parameter int CTR_W = 27,
  parameter logic [8:0] IDLE_CODE = 9'h1F0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [8:0] data0,
  input  logic [8:0] data1,
  input  logic [8:0] data2,
  output logic [2:0] ack,
  output logic [8:0] ssd_data,
  output logic       busy,
  output logic       done,
  output logic [1:0] active_src
);
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
  localparam logic [CTR_W-1:0] HOLD_END = CTR_W'(HOLD_CYCLES - 1);
  localparam logic [CTR_W-1:0] GAP_END = CTR_W'(GAP_CYCLES - 1);
  state_t state;
  logic [CTR_W-1:0] ctr;
  logic [1:0] rr_ptr, p1, p2, rr_g, gsel;
  logic [8:0] g_data;
  logic preempt, gnt;
  always_comb begin
    p1 = rr_ptr == 2'd2 ? 2'd0 : rr_ptr + 2'd1;
    p2 = rr_ptr == 2'd0 ? 2'd2 : rr_ptr - 2'd1;
    rr_g = req[rr_ptr] ? rr_ptr : req[p1] ? p1 : p2;
    preempt = req[0] && (state == GAP || (state == SHOW && active_src != 2'd0));
    gnt = preempt || (state == IDLE && |req);
    gsel = preempt ? 2'd0 : rr_g;
    g_data = gsel == 2'd0 ? data0 : gsel == 2'd1 ? data1 : data2;
  end
  // a grant (including preemption) overrides whatever SHOW/GAP would do this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ctr <= '0;
      rr_ptr <= 2'd0;
      ack <= 3'b000;
      ssd_data <= IDLE_CODE;
      busy <= 1'b0;
      done <= 1'b0;
      active_src <= 2'd3;
    end else begin
      ack <= 3'b000;
      done <= 1'b0;
      if (gnt) begin
        ack <= 3'b001 << gsel;
        ssd_data <= g_data;
        active_src <= gsel;
        ctr <= '0;
        busy <= 1'b1;
        rr_ptr <= gsel == 2'd2 ? 2'd0 : gsel + 2'd1;
        state <= SHOW;
      end else if (state == SHOW) begin
        if (ctr == HOLD_END) begin
          done <= 1'b1;
          ssd_data <= IDLE_CODE;
          active_src <= 2'd3;
          ctr <= '0;
          state <= GAP;
        end else begin
          ctr <= ctr + CTR_W'(1);
        end
      end else if (state == GAP) begin
        if (ctr == GAP_END) begin
          busy <= 1'b0;
          ctr <= '0;
          state <= IDLE;
        end else begin
          ctr <= ctr + CTR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ssd_display_scheduler.sv
// tb_ssd_display_scheduler: directed table, corner sequences and random stimulus against a countdown reference model.
module tb_ssd_display_scheduler;
  localparam int H = 4;
  localparam int G = 2;
  localparam logic [8:0] IDLE = 9'h1F0;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] req, ack;
  logic [8:0] data0, data1, data2, ssd_data;
  logic busy, done;
  logic [1:0] active_src;
  int checks = 0, errors = 0;
  int m_ph, m_left, m_ptr;
  logic [2:0] m_ack;
  logic [8:0] m_ssd;
  logic m_busy, m_done;
  logic [1:0] m_src;
  typedef struct {
    logic [2:0] req;
    logic [8:0] d1;
    logic [2:0] ack;
    logic [8:0] ssd;
    logic busy;
    logic done;
    logic [1:0] src;
  } vec_t;
  vec_t tbl[8];

  ssd_display_scheduler #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CTR_W(27), .IDLE_CODE(IDLE)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
    .ack(ack), .ssd_data(ssd_data), .busy(busy), .done(done), .active_src(active_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // phases: 0 idle, 1 showing, 2 gap; m_left counts remaining cycles of the phase
  task automatic m_reset();
    m_ph = 0; m_left = 0; m_ptr = 0; m_ack = 3'b000; m_ssd = IDLE;
    m_busy = 1'b0; m_done = 1'b0; m_src = 2'd3;
  endtask

  task automatic m_grant(input int g);
    m_ack = 3'(1 << g);
    m_ssd = g == 0 ? data0 : g == 1 ? data1 : data2;
    m_src = 2'(g);
    m_busy = 1'b1;
    m_ph = 1;
    m_left = H;
    m_ptr = (g + 1) % 3;
  endtask

  task automatic m_step();
    int g;
    m_ack = 3'b000;
    m_done = 1'b0;
    if (req[0] && (m_ph == 2 || (m_ph == 1 && m_src != 2'd0))) m_grant(0);
    else if (m_ph == 0) begin
      g = -1;
      for (int k = 0; k < 3; k++) if (g < 0 && req[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      if (g >= 0) m_grant(g);
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_ph == 1) begin
          m_done = 1'b1; m_ssd = IDLE; m_src = 2'd3; m_ph = 2; m_left = G;
        end else begin
          m_busy = 1'b0; m_ph = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    @(negedge clk);
    chk("ack", 32'(ack), 32'(m_ack));
    chk("ssd_data", 32'(ssd_data), 32'(m_ssd));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("active_src", 32'(active_src), 32'(m_src));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ssd"}, 32'(ssd_data), 32'(IDLE));
    chk({tag, "_src"}, 32'(active_src), 32'd3);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic wait_ack(input string tag, output bit hit);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc();
      if (ack != 3'b000) hit = 1;
    end
    chk({tag, "_timeout"}, 32'(hit), 32'd1);
  endtask

  initial begin
    bit hit;
    int grants[$];
    int gtime[$];
    tbl[0] = '{3'b010, 9'h042, 3'b010, 9'h042, 1'b1, 1'b0, 2'd1};
    tbl[1] = '{3'b000, 9'h000, 3'b000, 9'h042, 1'b1, 1'b0, 2'd1};
    tbl[2] = '{3'b000, 9'h000, 3'b000, 9'h042, 1'b1, 1'b0, 2'd1};
    tbl[3] = '{3'b000, 9'h000, 3'b000, 9'h042, 1'b1, 1'b0, 2'd1};
    tbl[4] = '{3'b000, 9'h000, 3'b000, IDLE, 1'b1, 1'b1, 2'd3};
    tbl[5] = '{3'b000, 9'h000, 3'b000, IDLE, 1'b1, 1'b0, 2'd3};
    tbl[6] = '{3'b000, 9'h000, 3'b000, IDLE, 1'b0, 1'b0, 2'd3};
    tbl[7] = '{3'b000, 9'h000, 3'b000, IDLE, 1'b0, 1'b0, 2'd3};
    rst = 1'b1; req = 3'b000; data0 = '0; data1 = '0; data2 = '0;
    m_reset();
    cyc(); cyc();
    chk_reset_vals("reset");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; data1 = tbl[i].d1;
      cyc();
      chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_ssd", i), 32'(ssd_data), 32'(tbl[i].ssd));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_src", i), 32'(active_src), 32'(tbl[i].src));
    end
    // requests held from reset: round-robin order 1, 2, 1 with H+G+1 cycle spacing
    rst = 1'b1; req = 3'b110; data1 = 9'h011; data2 = 9'h022;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 60 && grants.size() < 3; i++) begin
      cyc();
      if (ack != 3'b000) begin
        grants.push_back(ack == 3'b010 ? 1 : ack == 3'b100 ? 2 : 0);
        gtime.push_back(i);
      end
    end
    chk("rr_count", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      chk("rr_first", 32'(grants[0]), 32'd1);
      chk("rr_second", 32'(grants[1]), 32'd2);
      chk("rr_third", 32'(grants[2]), 32'd1);
      chk("rr_spacing", 32'(gtime[1] - gtime[0]), 32'(H + G + 1));
    end
    req = 3'b000;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin cyc(); if (!busy) hit = 1; end
    chk("idle_timeout", 32'(hit), 32'd1);
    // source 2 preempted in its second SHOW cycle
    req = 3'b100; data2 = 9'h0AB;
    cyc();
    chk("src2_ack", 32'(ack), 32'b100);
    chk("src2_ssd", 32'(ssd_data), 32'h0AB);
    req = 3'b000;
    cyc();
    req = 3'b001; data0 = 9'h1FF;
    cyc();
    chk("pre_ack", 32'(ack), 32'b001);
    chk("pre_ssd", 32'(ssd_data), 32'h1FF);
    chk("pre_src", 32'(active_src), 32'd0);
    // source 0 showing cannot be re-preempted; after its gap rr_ptr=1 picks source 1
    req = 3'b011; data1 = 9'h033;
    cyc();
    chk("nore_ack", 32'(ack), 32'd0);
    chk("nore_ssd", 32'(ssd_data), 32'h1FF);
    req = 3'b010;
    wait_ack("after_src0", hit);
    chk("after_src0_ack", 32'(ack), 32'b010);
    chk("after_src0_ssd", 32'(ssd_data), 32'h033);
    req = 3'b000;
    // req[0] arriving in the last GAP cycle preempts with no IDLE cycle
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin cyc(); if (done) hit = 1; end
    chk("done_timeout", 32'(hit), 32'd1);
    cyc();
    req = 3'b001; data0 = 9'h155;
    cyc();
    chk("gap_pre_ack", 32'(ack), 32'b001);
    chk("gap_pre_busy", 32'(busy), 32'd1);
    chk("gap_pre_ssd", 32'(ssd_data), 32'h155);
    req = 3'b000;
    cyc();
    // asynchronous reset mid-SHOW takes effect before the next edge
    #2 rst = 1'b1;
    #1 chk_reset_vals("async");
    m_reset();
    cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 3000; i++) begin
      req = $urandom_range(0, 3) == 0 ? 3'($urandom_range(1, 7)) : 3'b000;
      data0 = 9'($urandom); data1 = 9'($urandom); data2 = 9'($urandom);
      rst = $urandom_range(0, 299) == 0;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
